// File: rtl/instr_mem_loader.sv
// Byte-stream programmer for the instruction memory write port.
// Parses SYNC/LEN/data/CHK frames and writes little-endian words from address 0.
module instr_mem_loader #(
    parameter int          DEPTH     = 128,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        instr_we,
    output logic [31:0] instr_waddr,
    output logic [31:0] instr_wdata,
    output logic        cpu_hold,
    output logic        load_done,
    output logic        load_err
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK, S_DONE, S_ERROR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_word_idx;
    logic [1:0]         r_byte_idx;
    logic [15:0]        r_len;
    logic [7:0]         r_acc;
    logic [23:0]        r_word;
    logic               r_rx_ready;
    logic               r_we;
    logic [31:0]        r_waddr;
    logic [31:0]        r_wdata;
    logic               r_hold;
    logic               r_done;
    logic               r_err;

    logic               w_fire;
    logic               w_we;
    logic [15:0]        w_len_full;
    logic               w_last_word;
    logic               w_ready;
    logic               w_hold;

    assign w_fire      = rx_valid && r_rx_ready;
    assign w_len_full  = {rx_data, r_len[7:0]};
    assign w_last_word = (16'(r_word_idx) == (r_len - 16'd1));

    // Next-state decode and write strobe; start overrides any byte in flight
    always_comb begin
        w_next = r_state;
        w_we   = 1'b0;
        if (start) begin
            w_next = S_SYNC;
        end else if (w_fire) begin
            case (r_state)
                S_SYNC: begin
                    if (rx_data == SYNC_BYTE) begin
                        w_next = S_LEN_LO;
                    end else begin
                        w_next = S_SYNC;
                    end
                end
                S_LEN_LO: w_next = S_LEN_HI;
                S_LEN_HI: begin
                    if (w_len_full > 16'(DEPTH)) begin
                        w_next = S_ERROR;
                    end else if (w_len_full == 16'd0) begin
                        w_next = S_CHECK;
                    end else begin
                        w_next = S_DATA;
                    end
                end
                S_DATA: begin
                    if (r_byte_idx == 2'd3) begin
                        w_we = 1'b1;
                        if (w_last_word) begin
                            w_next = S_CHECK;
                        end else begin
                            w_next = S_DATA;
                        end
                    end else begin
                        w_next = S_DATA;
                    end
                end
                S_CHECK: begin
                    if (rx_data == r_acc) begin
                        w_next = S_DONE;
                    end else begin
                        w_next = S_ERROR;
                    end
                end
                default: w_next = r_state;
            endcase
        end else begin
            w_next = r_state;
        end
    end

    // Status outputs are decoded from the next state so they register alongside it
    always_comb begin
        w_ready = 1'b0;
        w_hold  = 1'b1;
        case (w_next)
            S_SYNC, S_LEN_LO, S_LEN_HI, S_DATA, S_CHECK: w_ready = 1'b1;
            S_IDLE, S_DONE:                              w_hold  = 1'b0;
            default:                                     w_ready = 1'b0;
        endcase
    end

    // State and status registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_rx_ready <= 1'b0;
            r_hold     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_rx_ready <= w_ready;
            r_hold     <= w_hold;
            r_done     <= (w_next == S_DONE);
            r_err      <= (w_next == S_ERROR);
        end
    end

    // Frame datapath: length, word assembly, checksum and write port
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_word_idx <= '0;
            r_byte_idx <= 2'd0;
            r_len      <= 16'd0;
            r_acc      <= 8'd0;
            r_word     <= 24'd0;
            r_we       <= 1'b0;
            r_waddr    <= 32'd0;
            r_wdata    <= 32'd0;
        end else begin
            r_we <= w_we;
            if (w_we) begin
                r_waddr <= 32'({r_word_idx, 2'b00});
                r_wdata <= {rx_data, r_word};
            end
            if (start) begin
                r_word_idx <= '0;
                r_byte_idx <= 2'd0;
                r_len      <= 16'd0;
                r_acc      <= 8'd0;
            end else if (w_fire) begin
                case (r_state)
                    S_LEN_LO: r_len[7:0] <= rx_data;
                    S_LEN_HI: begin
                        r_len[15:8] <= rx_data;
                        r_word_idx  <= '0;
                        r_byte_idx  <= 2'd0;
                        r_acc       <= 8'd0;
                    end
                    S_DATA: begin
                        r_word     <= {rx_data, r_word[23:8]};
                        r_acc      <= r_acc ^ rx_data;
                        r_byte_idx <= r_byte_idx + 2'd1;
                        // Index stops at the last word so it never reaches DEPTH
                        if ((r_byte_idx == 2'd3) && !w_last_word) begin
                            r_word_idx <= r_word_idx + IDX_W'(1);
                        end
                    end
                    default: r_len <= r_len;
                endcase
            end
        end
    end

    assign rx_ready    = r_rx_ready;
    assign instr_we    = r_we;
    assign instr_waddr = r_waddr;
    assign instr_wdata = r_wdata;
    assign cpu_hold    = r_hold;
    assign load_done   = r_done;
    assign load_err    = r_err;

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: frame-level model plus per-cycle write compare.
module tb_instr_mem_loader;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        instr_we;
    logic [31:0] instr_waddr;
    logic [31:0] instr_wdata;
    logic        cpu_hold;
    logic        load_done;
    logic        load_err;

    int total = 0;
    int bad   = 0;

    logic [7:0]  stim[$];
    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_data_q[$];
    int          exp_res;
    logic [31:0] last_addr;
    logic [31:0] last_data;

    instr_mem_loader #(.DEPTH(128), .SYNC_BYTE(8'hA5)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .instr_we(instr_we), .instr_waddr(instr_waddr), .instr_wdata(instr_wdata),
        .cpu_hold(cpu_hold), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Every write strobe cycle must match the next expected write
    always @(negedge clk) begin
        if (reset_n === 1'b1 && instr_we === 1'b1) begin
            if (exp_addr_q.size() == 0) begin
                check("unexpected_write", instr_waddr, 32'hFFFF_FFFF);
            end else begin
                check("write_addr", instr_waddr, exp_addr_q.pop_front());
                check("write_data", instr_wdata, exp_data_q.pop_front());
            end
            last_addr = instr_waddr;
            last_data = instr_wdata;
        end
    end

    // Frame-level interpretation of the stimulus: skip to sync, read LEN, fold words and XOR
    task automatic model_frame();
        int i = 0;
        int len;
        logic [7:0] chk = 8'd0;
        while (i < stim.size() && stim[i] != 8'hA5) i++;
        i++;
        len = int'(stim[i]) + 256 * int'(stim[i+1]);
        i += 2;
        if (len > 128) begin
            exp_res = 2;
            return;
        end
        for (int w = 0; w < len; w++) begin
            exp_addr_q.push_back(32'(w * 4));
            exp_data_q.push_back({stim[i+3], stim[i+2], stim[i+1], stim[i]});
            for (int k = 0; k < 4; k++) chk = chk ^ stim[i+k];
            i += 4;
        end
        exp_res = (stim[i] == chk) ? 1 : 2;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        int cnt = 0;
        if (gaps && $urandom_range(0, 1) == 0) begin
            rx_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        rx_data  = b;
        rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (cnt >= 50) check("rx_ready_timeout", 32'(rx_ready), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic send_stream(input bit gaps);
        for (int k = 0; k < stim.size(); k++) send_byte(stim[k], gaps);
        rx_valid = 1'b0;
    endtask

    task automatic check_status(input string nm, input logic done_e, input logic err_e,
                                input logic hold_e, input logic ready_e);
        check({nm, "_status"}, {28'd0, load_done, load_err, cpu_hold, rx_ready},
              {28'd0, done_e, err_e, hold_e, ready_e});
    endtask

    task automatic run_frame(input string nm, input bit gaps);
        model_frame();
        pulse_start();
        check({nm, "_armed"}, {30'd0, rx_ready, cpu_hold}, 32'd3);
        send_stream(gaps);
        if (exp_res == 1) check_status(nm, 1'b1, 1'b0, 1'b0, 1'b0);
        else              check_status(nm, 1'b0, 1'b1, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check({nm, "_writes_left"}, 32'(exp_addr_q.size()), 32'd0);
    endtask

    initial begin
        reset_n  = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            check("reset_flags", {27'd0, rx_ready, instr_we, cpu_hold, load_done, load_err}, 32'd0);
            check("reset_waddr", instr_waddr, 32'd0);
            check("reset_wdata", instr_wdata, 32'd0);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("idle_ready", {31'd0, rx_ready}, 32'd0);
        rx_valid = 1'b0;
        pulse_start();
        check("start_ready_hold", {30'd0, rx_ready, cpu_hold}, 32'd3);

        // Two-word load
        stim = {8'hA5, 8'h02, 8'h00, 8'hb3, 8'h82, 8'h41, 8'h00,
                8'h33, 8'h03, 8'h74, 8'h40, 8'h74};
        model_frame();
        check("pin_w0", exp_data_q[0], 32'h004182b3);
        check("pin_w1", exp_data_q[1], 32'h40740333);
        check("pin_res_ok", 32'(exp_res), 32'd1);
        exp_addr_q.delete(); exp_data_q.delete();
        run_frame("two_word", 1'b0);

        // Checksum mismatch
        stim[11] = 8'h75;
        run_frame("bad_chk", 1'b0);

        // Sync hunt with valid gaps
        stim = {8'h00, 8'hFF, 8'hA5, 8'h01, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h13};
        run_frame("sync_hunt", 1'b1);
        check("sync_hunt_addr", last_addr, 32'h0);
        check("sync_hunt_data", last_data, 32'h00000013);

        // Length over DEPTH
        stim = {8'hA5, 8'h81, 8'h00};
        run_frame("len129", 1'b0);

        // Zero length
        stim = {8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame("len0", 1'b0);

        // Full depth
        stim = {8'hA5, 8'h80, 8'h00};
        for (int k = 0; k < 512; k++) stim.push_back(8'(k));
        stim.push_back(8'h00);
        model_frame();
        check("pin_last_addr", exp_addr_q[127], 32'h1FC);
        check("pin_last_data", exp_data_q[127], 32'hFFFEFDFC);
        exp_addr_q.delete(); exp_data_q.delete();
        run_frame("len128", 1'b0);
        check("len128_last_addr", last_addr, 32'h1FC);
        check("len128_last_data", last_data, 32'hFFFEFDFC);

        // Restart on the 4th byte of word 1
        exp_addr_q.push_back(32'h0);
        exp_data_q.push_back(32'h44332211);
        pulse_start();
        stim = {8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77};
        send_stream(1'b0);
        rx_data  = 8'h88;
        rx_valid = 1'b1;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        rx_valid = 1'b0;
        check("restart_we", {31'd0, instr_we}, 32'd0);
        check_status("restart", 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check("restart_writes_left", 32'(exp_addr_q.size()), 32'd0);
        stim = {8'hA5, 8'h01, 8'h00, 8'hde, 8'had, 8'hbe, 8'hef, 8'h22};
        model_frame();
        send_stream(1'b0);
        check_status("after_restart", 1'b1, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check("after_restart_writes_left", 32'(exp_addr_q.size()), 32'd0);
        check("after_restart_addr", last_addr, 32'h0);
        check("after_restart_data", last_data, 32'hefbeadde);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
